// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART transmitter and receiver.
// Contents:
//   PAR_NONE / PAR_EVEN / PAR_ODD  - parity_mode encodings (2'b11 acts as none)
//   uart_state_e                   - frame FSM states
//   parity_enabled()               - true when a parity bit follows the data
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    // The reserved encoding 2'b11 behaves exactly like PAR_NONE.
    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// ---------------------------------------------------------------------------
// uart_fifo
// Synchronous first-word-fall-through FIFO that queues words for the
// transmitter. rd_data_o always shows the oldest word while not empty.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset (empties the FIFO)
//   wr_data_i    - word to enqueue, written when wr_en_i && !full_o
//   rd_en_i      - dequeue the word on rd_data_o (ignored while empty)
//   full_o       - DEPTH words held
//   empty_o      - no words held
//   level_o      - occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     wr_en_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push;
    logic             pop;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign level_o   = count_q;
    assign rd_data_o = mem[rdPtr_q];
    assign push      = wr_en_i && !full_o;
    assign pop       = rd_en_i && !empty_o;

    // Pointer and occupancy update. DEPTH is a power of two, so the
    // pointers wrap on their own; a push and pop in the same cycle leave
    // the count unchanged.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (push) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control registers; reset only clears pointers and count, the storage
    // contents are don't-care once the FIFO is empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Storage array, written at the write pointer on an accepted push.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// ---------------------------------------------------------------------------
// uart_tx_buffered
// UART transmitter fed by a FIFO. Frames are start(0), DATA_BITS data bits
// LSB first, optional parity, then one or two stop bits (1).
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   wr_data      - word to enqueue, accepted when wr_en && ready
//   wr_en        - enqueue request
//   ready        - FIFO not full
//   parity_mode  - 00 none, 01 even, 10 odd, 11 none (sampled at pop)
//   two_stop     - 1 selects two stop bits (sampled at pop)
//   tx           - serial line, idle high
//   busy         - frame on the line or words waiting
//   level        - FIFO occupancy
//   overflow     - sticky, set by a write while full
// ---------------------------------------------------------------------------
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLOCK_RATE = 100000000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          wr_data,
    input  logic                          wr_en,
    output logic                          ready,
    input  logic [1:0]                    parity_mode,
    input  logic                          two_stop,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow
);

    localparam int RATE  = CLOCK_RATE / BAUD_RATE;
    localparam int CNT_W = $clog2(RATE) + 1;
    localparam int BIT_W = $clog2(DATA_BITS);

    uart_state_e          state_q, state_d;
    logic [CNT_W-1:0]     baudCnt_q, baudCnt_d;
    logic [BIT_W-1:0]     bitIdx_q, bitIdx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 parBit_q, parBit_d;
    logic                 parEn_q, parEn_d;
    logic                 twoStop_q, twoStop_d;
    logic                 stopIdx_q, stopIdx_d;
    logic                 tx_q, tx_d;
    logic                 lineActive_q;
    logic                 overflow_q, overflow_d;
    logic                 bitDone;
    logic                 loadWord;
    logic                 fifoPop;
    logic                 fifoFull;
    logic                 fifoEmpty;
    logic [DATA_BITS-1:0] fifoData;

    uart_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_data_i (wr_data),
        .wr_en_i   (wr_en),
        .rd_en_i   (fifoPop),
        .rd_data_o (fifoData),
        .full_o    (fifoFull),
        .empty_o   (fifoEmpty),
        .level_o   (level)
    );

    assign bitDone    = (baudCnt_q == CNT_W'(RATE - 1));
    assign ready      = !fifoFull;
    assign tx         = tx_q;
    assign overflow   = overflow_q;
    // lineActive_q covers the last stop-bit cycle still leaving the tx
    // register after the FSM has already returned to IDLE.
    assign busy       = (state_q != IDLE) || lineActive_q || !fifoEmpty;
    assign overflow_d = overflow_q || (wr_en && fifoFull);

    // Frame sequencer. Every non-IDLE state lasts whole bit periods of RATE
    // cycles. The line level is registered, so tx trails the state by one
    // cycle. Popping the next word directly out of the final stop period
    // keeps back-to-back frames gap-free. Line settings are captured at the
    // pop so later changes to parity_mode/two_stop cannot corrupt a frame.
    always_comb begin
        state_d   = state_q;
        baudCnt_d = baudCnt_q;
        bitIdx_d  = bitIdx_q;
        shift_d   = shift_q;
        parBit_d  = parBit_q;
        parEn_d   = parEn_q;
        twoStop_d = twoStop_q;
        stopIdx_d = stopIdx_q;
        tx_d      = 1'b1;
        loadWord  = 1'b0;
        fifoPop   = 1'b0;

        if (state_q != IDLE) begin
            baudCnt_d = bitDone ? '0 : baudCnt_q + CNT_W'(1);
        end

        unique case (state_q)
            IDLE: begin
                loadWord = !fifoEmpty;
            end
            START: begin
                tx_d = 1'b0;
                if (bitDone) begin
                    state_d  = DATA;
                    bitIdx_d = '0;
                end
            end
            DATA: begin
                tx_d = shift_q[0];
                if (bitDone) begin
                    shift_d = shift_q >> 1;
                    if (bitIdx_q == BIT_W'(DATA_BITS - 1)) begin
                        state_d   = parEn_q ? PARITY : STOP;
                        stopIdx_d = 1'b0;
                    end else begin
                        bitIdx_d = bitIdx_q + BIT_W'(1);
                    end
                end
            end
            PARITY: begin
                tx_d = parBit_q;
                if (bitDone) begin
                    state_d   = STOP;
                    stopIdx_d = 1'b0;
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (bitDone) begin
                    if (twoStop_q && !stopIdx_q) begin
                        stopIdx_d = 1'b1;
                    end else if (!fifoEmpty) begin
                        loadWord = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (loadWord) begin
            fifoPop   = 1'b1;
            shift_d   = fifoData;
            parEn_d   = parity_enabled(parity_mode);
            parBit_d  = (^fifoData) ^ (parity_mode == PAR_ODD);
            twoStop_d = two_stop;
            baudCnt_d = '0;
            state_d   = START;
        end
    end

    // State, counters and line register. Reset abandons any frame in
    // flight and forces the line to idle immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            baudCnt_q    <= '0;
            bitIdx_q     <= '0;
            shift_q      <= '0;
            parBit_q     <= 1'b0;
            parEn_q      <= 1'b0;
            twoStop_q    <= 1'b0;
            stopIdx_q    <= 1'b0;
            tx_q         <= 1'b1;
            lineActive_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            baudCnt_q    <= baudCnt_d;
            bitIdx_q     <= bitIdx_d;
            shift_q      <= shift_d;
            parBit_q     <= parBit_d;
            parEn_q      <= parEn_d;
            twoStop_q    <= twoStop_d;
            stopIdx_q    <= stopIdx_d;
            tx_q         <= tx_d;
            lineActive_q <= (state_q != IDLE);
            overflow_q   <= overflow_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_buffered
// Self-checking bench for uart_tx_buffered at RATE = 16 cycles per bit.
// Each written word pushes an expected frame; a line monitor pops the
// expectation when a start bit appears, compares the waveform cycle by
// cycle and hands a record to the scenario tasks for checking.
// ---------------------------------------------------------------------------
module tb_uart_tx_buffered;

    localparam int BIT_CYC = 16;

    typedef struct {
        logic [7:0] data;
        logic [1:0] pm;
        logic       ts;
    } exp_t;

    typedef struct {
        bit         unexpected;
        logic [7:0] expData;
        logic [7:0] gotData;
        bit         hasPar;
        logic       expPar;
        logic       gotPar;
        int         badCycles;
        longint     startCyc;
        int         len;
    } obs_t;

    logic       clk;
    logic       rst;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       ready;
    logic [1:0] parity_mode;
    logic       two_stop;
    logic       tx;
    logic       busy;
    logic [4:0] level;
    logic       overflow;

    exp_t   expQ[$];
    obs_t   obsQ[$];
    longint cyc;
    longint wrCyc;
    int     checksPassed;
    int     checksTotal;

    logic [15:0] monBits;
    int          monNBits;
    int          monT;
    int          monIdx;
    bit          monActive;
    obs_t        monRec;
    exp_t        monExp;

    uart_tx_buffered #(
        .CLOCK_RATE (1600000),
        .BAUD_RATE  (100000),
        .DATA_BITS  (8),
        .FIFO_DEPTH (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_data     (wr_data),
        .wr_en       (wr_en),
        .ready       (ready),
        .parity_mode (parity_mode),
        .two_stop    (two_stop),
        .tx          (tx),
        .busy        (busy),
        .level       (level),
        .overflow    (overflow)
    );

    // Free-running clock, posedges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Rising-edge counter used to time-stamp writes and frames.
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Line monitor: on a start bit, pop the next expected word, build the
    // expected bit sequence and compare tx against it on every cycle.
    always @(negedge clk) begin
        if (rst) begin
            monActive = 1'b0;
        end else begin
            if (!monActive && tx === 1'b0) begin
                monActive = 1'b1;
                monT      = 0;
                monRec    = '{default: 0};
                if (expQ.size() > 0) begin
                    monExp = expQ.pop_front();
                end else begin
                    monExp = '{data: 8'h00, pm: 2'b00, ts: 1'b0};
                    monRec.unexpected = 1'b1;
                end
                monBits    = '1;
                monBits[0] = 1'b0;
                for (int i = 0; i < 8; i++) monBits[1 + i] = monExp.data[i];
                monNBits = 9;
                if (monExp.pm == 2'b01 || monExp.pm == 2'b10) begin
                    monRec.hasPar = 1'b1;
                    monRec.expPar = (^monExp.data) ^ (monExp.pm == 2'b10);
                    monBits[9]    = monRec.expPar;
                    monNBits      = 10;
                end
                monNBits        = monNBits + (monExp.ts ? 2 : 1);
                monRec.expData  = monExp.data;
                monRec.startCyc = cyc;
                monRec.len      = BIT_CYC * monNBits;
            end else if (monActive) begin
                monT++;
            end
            if (monActive) begin
                monIdx = monT / BIT_CYC;
                if (tx !== monBits[monIdx]) monRec.badCycles++;
                if (monT % BIT_CYC == BIT_CYC / 2) begin
                    if (monIdx >= 1 && monIdx <= 8) monRec.gotData[monIdx - 1] = tx;
                    if (monRec.hasPar && monIdx == 9) monRec.gotPar = tx;
                end
                if (monT == monRec.len - 1) begin
                    obsQ.push_back(monRec);
                    monActive = 1'b0;
                end
            end
        end
    end

    // Drive one write for one clock edge and record the edge it lands on.
    task automatic writeWord(input logic [7:0] d, input logic [1:0] pm,
                             input logic ts, input bit accept);
        @(negedge clk);
        wr_data     = d;
        parity_mode = pm;
        two_stop    = ts;
        wr_en       = 1'b1;
        @(posedge clk);
        #1;
        wrCyc = cyc;
        wr_en = 1'b0;
        if (accept) expQ.push_back('{data: d, pm: pm, ts: ts});
    endtask

    task automatic waitFrames(input int n, input int budget);
        for (int i = 0; i < budget && obsQ.size() < n; i++) @(posedge clk);
    endtask

    task automatic waitUntilCyc(input longint target);
        for (int i = 0; i < 5000 && cyc < target; i++) @(negedge clk);
    endtask

    // Asynchronous reset values, then a write on the first edge after release.
    task automatic test_reset();
        obs_t   f;
        longint n;
        rst = 1'b0; wr_en = 1'b0; wr_data = '0; parity_mode = 2'b00; two_stop = 1'b0;
        #2 rst = 1'b1;
        #1;
        checksTotal++;
        if (tx !== 1'b1) $display("[TB] FAIL reset_tx got=%b want=1", tx); else checksPassed++;
        checksTotal++;
        if (busy !== 1'b0) $display("[TB] FAIL reset_busy got=%b want=0", busy); else checksPassed++;
        checksTotal++;
        if (ready !== 1'b1) $display("[TB] FAIL reset_ready got=%b want=1", ready); else checksPassed++;
        checksTotal++;
        if (level !== 5'd0) $display("[TB] FAIL reset_level got=%0d want=0", level); else checksPassed++;
        checksTotal++;
        if (overflow !== 1'b0) $display("[TB] FAIL reset_overflow got=%b want=0", overflow); else checksPassed++;
        repeat (3) @(negedge clk);
        wr_data = 8'h3C; parity_mode = 2'b00; two_stop = 1'b0; wr_en = 1'b1;
        rst = 1'b0;
        expQ.push_back('{data: 8'h3C, pm: 2'b00, ts: 1'b0});
        @(posedge clk);
        #1;
        n = cyc;
        wr_en = 1'b0;
        @(negedge clk);
        checksTotal++;
        if (level !== 5'd1) $display("[TB] FAIL first_write_level got=%0d want=1", level); else checksPassed++;
        waitFrames(1, 400);
        checksTotal++;
        if (obsQ.size() != 1) $display("[TB] FAIL first_write_frames got=%0d want=1", obsQ.size());
        else begin
            checksPassed++;
            f = obsQ.pop_front();
            checksTotal++;
            if (f.unexpected || f.gotData !== 8'h3C || f.badCycles != 0 || f.startCyc != n + 2)
                $display("[TB] FAIL first_write_frame got=%h bad=%0d start=%0d want=3c bad=0 start=%0d",
                         f.gotData, f.badCycles, f.startCyc, n + 2);
            else checksPassed++;
        end
    endtask

    // 0x55, no parity, one stop: latency, bit pattern, length, busy fall.
    task automatic test_basic();
        obs_t   f;
        longint n;
        @(negedge clk);
        writeWord(8'h55, 2'b00, 1'b0, 1'b1);
        n = wrCyc;
        @(negedge clk);
        checksTotal++;
        if (busy !== 1'b1) $display("[TB] FAIL basic_busy_queued got=%b want=1", busy); else checksPassed++;
        @(negedge clk);
        checksTotal++;
        if (tx !== 1'b1) $display("[TB] FAIL basic_tx_n1 got=%b want=1", tx); else checksPassed++;
        @(negedge clk);
        checksTotal++;
        if (tx !== 1'b0) $display("[TB] FAIL basic_tx_n2 got=%b want=0", tx); else checksPassed++;
        waitUntilCyc(n + 161);
        checksTotal++;
        if (busy !== 1'b1) $display("[TB] FAIL basic_busy_last_stop got=%b want=1", busy); else checksPassed++;
        @(negedge clk);
        checksTotal++;
        if (busy !== 1'b0) $display("[TB] FAIL basic_busy_fall got=%b want=0", busy); else checksPassed++;
        waitFrames(1, 200);
        checksTotal++;
        if (obsQ.size() != 1) $display("[TB] FAIL basic_frames got=%0d want=1", obsQ.size());
        else begin
            checksPassed++;
            f = obsQ.pop_front();
            checksTotal++;
            if (f.unexpected || f.gotData !== 8'h55)
                $display("[TB] FAIL basic_data got=%h want=55", f.gotData);
            else checksPassed++;
            checksTotal++;
            if (f.badCycles != 0 || f.len != 160)
                $display("[TB] FAIL basic_wave bad=%0d len=%0d want bad=0 len=160", f.badCycles, f.len);
            else checksPassed++;
        end
    endtask

    // Even parity on 0x07 and odd parity on 0x00 both give a parity bit of 1.
    task automatic test_parity();
        obs_t       f;
        logic [7:0] d;
        logic [1:0] pm;
        for (int i = 0; i < 2; i++) begin
            d  = (i == 0) ? 8'h07 : 8'h00;
            pm = (i == 0) ? 2'b01 : 2'b10;
            writeWord(d, pm, 1'b0, 1'b1);
            waitFrames(1, 400);
            checksTotal++;
            if (obsQ.size() != 1) $display("[TB] FAIL parity_frames case=%0d got=%0d want=1", i, obsQ.size());
            else begin
                checksPassed++;
                f = obsQ.pop_front();
                checksTotal++;
                if (f.unexpected || f.gotData !== d || f.gotPar !== 1'b1)
                    $display("[TB] FAIL parity_bit case=%0d got=%h/%b want=%h/1", i, f.gotData, f.gotPar, d);
                else checksPassed++;
                checksTotal++;
                if (f.badCycles != 0 || f.len != 176)
                    $display("[TB] FAIL parity_wave case=%0d bad=%0d len=%0d want bad=0 len=176", i, f.badCycles, f.len);
                else checksPassed++;
            end
            repeat (4) @(negedge clk);
        end
    endtask

    // 0xA3 with two stop bits; two_stop is dropped mid-frame and must not matter.
    task automatic test_two_stop();
        obs_t   f;
        longint n;
        writeWord(8'hA3, 2'b00, 1'b1, 1'b1);
        n = wrCyc;
        waitUntilCyc(n + 60);
        two_stop = 1'b0;
        waitUntilCyc(n + 177);
        checksTotal++;
        if (busy !== 1'b1) $display("[TB] FAIL two_stop_busy_second_stop got=%b want=1", busy); else checksPassed++;
        @(negedge clk);
        checksTotal++;
        if (busy !== 1'b0) $display("[TB] FAIL two_stop_busy_fall got=%b want=0", busy); else checksPassed++;
        waitFrames(1, 100);
        checksTotal++;
        if (obsQ.size() != 1) $display("[TB] FAIL two_stop_frames got=%0d want=1", obsQ.size());
        else begin
            checksPassed++;
            f = obsQ.pop_front();
            checksTotal++;
            if (f.unexpected || f.gotData !== 8'hA3 || f.badCycles != 0 || f.len != 176)
                $display("[TB] FAIL two_stop_frame got=%h bad=%0d len=%0d want=a3 bad=0 len=176",
                         f.gotData, f.badCycles, f.len);
            else checksPassed++;
        end
        repeat (4) @(negedge clk);
    endtask

    // Three words on consecutive cycles give three contiguous frames.
    task automatic test_back_to_back();
        obs_t   f;
        longint n;
        int     busyHigh;
        logic [7:0] d;
        writeWord(8'h01, 2'b00, 1'b0, 1'b1);
        n = wrCyc;
        writeWord(8'h02, 2'b00, 1'b0, 1'b1);
        writeWord(8'h03, 2'b00, 1'b0, 1'b1);
        busyHigh = 0;
        for (int i = 0; i < 480; i++) begin
            @(negedge clk);
            if (busy === 1'b1) busyHigh++;
        end
        checksTotal++;
        if (busyHigh != 480) $display("[TB] FAIL b2b_busy_cycles got=%0d want=480", busyHigh); else checksPassed++;
        @(negedge clk);
        checksTotal++;
        if (busy !== 1'b0) $display("[TB] FAIL b2b_busy_fall got=%b want=0", busy); else checksPassed++;
        waitFrames(3, 100);
        checksTotal++;
        if (obsQ.size() != 3) $display("[TB] FAIL b2b_frames got=%0d want=3", obsQ.size());
        else begin
            checksPassed++;
            for (int k = 0; k < 3; k++) begin
                f = obsQ.pop_front();
                d = 8'(k + 1);
                checksTotal++;
                if (f.unexpected || f.gotData !== d || f.badCycles != 0 || f.startCyc != n + 2 + 160 * k)
                    $display("[TB] FAIL b2b_frame%0d got=%h bad=%0d start=%0d want=%h bad=0 start=%0d",
                             k, f.gotData, f.badCycles, f.startCyc, d, n + 2 + 160 * k);
                else checksPassed++;
            end
        end
    endtask

    // 18 writes in a row: one pops early, 16 fill the FIFO, the 18th is lost.
    task automatic test_overflow();
        obs_t       f;
        longint     n;
        int         gapErrs;
        logic [7:0] d;
        for (int i = 0; i < 18; i++) begin
            d = 8'(8'h10 + i);
            writeWord(d, 2'b00, 1'b0, i < 17);
            if (i == 0) n = wrCyc;
            if (i == 1) begin
                checksTotal++;
                if (level !== 5'd1) $display("[TB] FAIL ovf_push_pop_level got=%0d want=1", level); else checksPassed++;
            end
        end
        checksTotal++;
        if (level !== 5'd16) $display("[TB] FAIL ovf_level_full got=%0d want=16", level); else checksPassed++;
        checksTotal++;
        if (ready !== 1'b0) $display("[TB] FAIL ovf_ready got=%b want=0", ready); else checksPassed++;
        checksTotal++;
        if (overflow !== 1'b1) $display("[TB] FAIL ovf_flag got=%b want=1", overflow); else checksPassed++;
        waitFrames(17, 17 * 160 + 100);
        @(negedge clk);
        checksTotal++;
        if (obsQ.size() != 17) $display("[TB] FAIL ovf_frames got=%0d want=17", obsQ.size());
        else begin
            checksPassed++;
            gapErrs = 0;
            for (int k = 0; k < 17; k++) begin
                f = obsQ.pop_front();
                d = 8'(8'h10 + k);
                if (f.startCyc != n + 2 + 160 * k) gapErrs++;
                checksTotal++;
                if (f.unexpected || f.gotData !== d || f.badCycles != 0)
                    $display("[TB] FAIL ovf_frame%0d got=%h bad=%0d want=%h bad=0", k, f.gotData, f.badCycles, d);
                else checksPassed++;
            end
            checksTotal++;
            if (gapErrs != 0) $display("[TB] FAIL ovf_contiguous got=%0d misplaced want=0", gapErrs); else checksPassed++;
        end
        checksTotal++;
        if (busy !== 1'b0 || level !== 5'd0)
            $display("[TB] FAIL ovf_drained busy=%b level=%0d want busy=0 level=0", busy, level);
        else checksPassed++;
        checksTotal++;
        if (overflow !== 1'b1) $display("[TB] FAIL ovf_sticky got=%b want=1", overflow); else checksPassed++;
    endtask

    // Reset 50 cycles into a frame with three words waiting.
    task automatic test_reset_midframe();
        longint n;
        int     txLow;
        writeWord(8'hC1, 2'b00, 1'b0, 1'b1);
        n = wrCyc;
        writeWord(8'hC2, 2'b00, 1'b0, 1'b1);
        writeWord(8'hC3, 2'b00, 1'b0, 1'b1);
        writeWord(8'hC4, 2'b00, 1'b0, 1'b1);
        waitUntilCyc(n + 52);
        checksTotal++;
        if (level !== 5'd3) $display("[TB] FAIL midrst_level_before got=%0d want=3", level); else checksPassed++;
        #2 rst = 1'b1;
        #1;
        checksTotal++;
        if (tx !== 1'b1) $display("[TB] FAIL midrst_tx got=%b want=1", tx); else checksPassed++;
        checksTotal++;
        if (level !== 5'd0 || busy !== 1'b0 || ready !== 1'b1 || overflow !== 1'b0)
            $display("[TB] FAIL midrst_state level=%0d busy=%b ready=%b ovf=%b want 0/0/1/0",
                     level, busy, ready, overflow);
        else checksPassed++;
        expQ.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        txLow = 0;
        for (int i = 0; i < 700; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) txLow++;
        end
        checksTotal++;
        if (txLow != 0 || obsQ.size() != 0)
            $display("[TB] FAIL midrst_quiet txlow=%0d frames=%0d want 0/0", txLow, obsQ.size());
        else checksPassed++;
        checksTotal++;
        if (busy !== 1'b0) $display("[TB] FAIL midrst_busy got=%b want=0", busy); else checksPassed++;
    endtask

    initial begin
        checksPassed = 0;
        checksTotal  = 0;
        monActive    = 1'b0;
        test_reset();
        test_basic();
        test_parity();
        test_two_stop();
        test_back_to_back();
        test_overflow();
        test_reset_midframe();
        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
